dcpu_mem_responder: RTL and testbench
=====================================

Name: dcpu_mem_responder

Overview:
Bus responder (target) side of the dcpu memory interface: accepts o_addr/o_dat/o_we/o_cs requests from the CPU, serves them from an internal word-addressed RAM and returns data with a single-cycle i_ack pulse. Programmable wait states model slow memory. An address window decoder lets several responders share one CPU bus. A write-protected low region holds boot code.

Parameters:
W, 16, data and address width (matches CPU)
AW, 10, RAM address bits; depth 2^AW words
BASE, 16'h0000, window base address; must be aligned to 2^AW
WP_LIMIT, 16'h0040, window-relative offsets below this are read-only
MAXWAIT_BITS, 4, width of wait-state configuration

Ports:
i_clk  in  1  clock, all logic on rising edge
i_reset_n  in  1  synchronous active-low reset
i_cs  in  1  request valid (CPU o_cs)
i_we  in  1  1=write, 0=read (CPU o_we)
i_addr  in  W  word address (CPU o_addr)
i_dat  in  W  write data (CPU o_dat)
o_dat  out  W  read data (to CPU i_dat)
o_ack  out  1  one-cycle completion pulse (to CPU i_ack)
o_err  out  1  one-cycle pulse with o_ack when a write was dropped
i_wait_cfg  in  MAXWAIT_BITS  wait cycles inserted per access
o_busy  out  1  access in progress (WAIT or ACK state)

Behaviour:
- One clock domain; reset is synchronous and active-low on i_reset_n, sampled at i_clk rising edge.
- Reset: state=IDLE, o_ack=0, o_err=0, o_dat=0, o_busy=0, wait counter=0. RAM contents are not cleared.
- Select: sel = i_cs && (i_addr[W-1:AW] == BASE[W-1:AW]). off = i_addr[AW-1:0].
- States: IDLE, WAIT, ACK.
- IDLE: if sel, latch off, i_we, i_dat and cnt=i_wait_cfg. Go to ACK if i_wait_cfg==0, else go to WAIT.
- WAIT: if !i_cs, abort to IDLE (no write, no ack). Otherwise decrement cnt. When cnt==1, go to ACK.
- Entering ACK, on the same edge:
  - Read: o_dat <= ram[latched off].
  - Write with off >= WP_LIMIT: ram[off] <= latched data.
  - Write with off < WP_LIMIT: RAM unchanged, o_err <= 1.
  - o_ack <= 1.
- ACK: lasts exactly one cycle. o_ack and o_err are then cleared and the block returns to IDLE. A request is never accepted in the ACK cycle, which prevents double-ack of a held i_cs.
- Latency: from sel sampled in IDLE to o_ack high is 1+i_wait_cfg cycles. Back-to-back accesses with i_cs held complete every 2+i_wait_cfg cycles.
- o_dat holds the last read value. Writes and idle cycles do not change it.
- Request fields are latched at acceptance, so changes on i_addr, i_dat or i_we during WAIT are ignored. Only a drop of i_cs aborts.
- i_wait_cfg changes take effect at the next acceptance only.
- Unselected requests (address outside the window) are ignored completely: no ack, state stays IDLE.
- i_reset_n low in any state forces the reset values on the next edge. A write in WAIT is lost; a write already committed on entry to ACK stays.
- o_busy = (state != IDLE).
- Offset arithmetic is modulo 2^AW and cannot leave the RAM.

Decomposition:
- Package dcpu_pkg holds:
  - the state enum (IDLE=2'd0, WAIT=2'd1, ACK=2'd2)
  - the bus width W
  - a shared localparam for the ack pulse width (1)
- Sub-module dcpu_ram_sp is natural: a single-port synchronous RAM with one registered read and a write enable, depth 2^AW. Its registered read output feeds o_dat directly.
- The FSM, decoder and write-protect logic stay in dcpu_mem_responder.

Test Plan:
1. Reset, then i_wait_cfg=0. Write 16'hBEEF to 16'h0100, then read 16'h0100 with i_cs held high -> each o_ack 1 cycle after acceptance, acks 2 cycles apart; read returns o_dat=16'hBEEF.
2. i_wait_cfg=3, read 16'h0200 preloaded with 16'h1234 -> o_ack exactly 4 cycles after acceptance; o_busy high for 4 cycles; o_dat=16'h1234 in the ack cycle.
3. Write 16'hDEAD to 16'h0010 (< WP_LIMIT) -> o_ack=1 and o_err=1 in the same cycle; a later read of 16'h0010 returns the prior value.
4. Access to 16'h0800 with BASE=0, AW=10 -> no o_ack for 20 cycles, o_busy stays 0.
5. i_wait_cfg=5, write 16'h5555 to 16'h0300, drop i_cs after 2 cycles -> no ack, state back to IDLE; a read of 16'h0300 returns the old value.
6. i_wait_cfg=4, assert i_reset_n=0 during WAIT of a write -> next cycle o_ack=0, o_busy=0, o_dat=0; write not committed.

Source files
------------

// File: rtl/dcpu_pkg.sv
// Shared definitions for the dcpu memory responder: bus width, FSM state
// encoding and ack pulse width.
package dcpu_pkg;

   localparam int unsigned W         = 16;
   localparam int unsigned ACK_PULSE = 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      ACK  = 2'd2
   } state_t;

endpackage

// File: rtl/dcpu_ram_sp.sv
// Single-port synchronous RAM, depth 2^AW, with a registered read that only
// updates on a read enable so the output holds the last value read.
module dcpu_ram_sp #(
   parameter int unsigned W  = 16,
   parameter int unsigned AW = 10
) (
   input  logic          i_clk,
   input  logic          i_reset_n,
   input  logic          i_we,
   input  logic          i_re,
   input  logic [AW-1:0] i_addr,
   input  logic [W-1:0]  i_wdat,
   output logic [W-1:0]  o_rdat
);

   logic [W-1:0] r_mem [2**AW];
   logic [W-1:0] r_rdat;

   // Storage is deliberately not reset; only the read register is.
   always_ff @(posedge i_clk) begin
      if (i_we) r_mem[i_addr] <= i_wdat;
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset_n)  r_rdat <= '0;
      else if (i_re)   r_rdat <= r_mem[i_addr];
   end

   assign o_rdat = r_rdat;

endmodule

// File: rtl/dcpu_mem_responder.sv
// Bus target for the dcpu memory interface: window decode, programmable wait
// states, write-protected low region, single-cycle ack.
module dcpu_mem_responder
   import dcpu_pkg::*;
#(
   parameter int unsigned   W            = dcpu_pkg::W,
   parameter int unsigned   AW           = 10,
   parameter logic [W-1:0]  BASE         = 16'h0000,
   parameter logic [W-1:0]  WP_LIMIT     = 16'h0040,
   parameter int unsigned   MAXWAIT_BITS = 4
) (
   input  logic                    i_clk,
   input  logic                    i_reset_n,
   input  logic                    i_cs,
   input  logic                    i_we,
   input  logic [W-1:0]            i_addr,
   input  logic [W-1:0]            i_dat,
   output logic [W-1:0]            o_dat,
   output logic                    o_ack,
   output logic                    o_err,
   input  logic [MAXWAIT_BITS-1:0] i_wait_cfg,
   output logic                    o_busy
);

   state_t                  r_state, w_next;
   logic [MAXWAIT_BITS-1:0] r_cnt;
   logic [AW-1:0]           r_off;
   logic                    r_we;
   logic [W-1:0]            r_dat;
   logic                    r_ack, r_err;

   logic                    w_sel;
   logic [AW-1:0]           w_off;
   logic                    w_we;
   logic [W-1:0]            w_dat;
   logic                    w_enter_ack, w_wp;
   logic                    w_ram_we, w_ram_re;

   assign w_sel = i_cs && (i_addr[W-1:AW] == BASE[W-1:AW]);

   // A zero-wait access commits on its acceptance edge, so the RAM sees the
   // live request in IDLE and the latched one afterwards.
   assign w_off = (r_state == IDLE) ? i_addr[AW-1:0] : r_off;
   assign w_we  = (r_state == IDLE) ? i_we : r_we;
   assign w_dat = (r_state == IDLE) ? i_dat : r_dat;
   assign w_wp  = ({{(W-AW){1'b0}}, w_off} < WP_LIMIT);

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_off   <= '0;
         r_we    <= 1'b0;
         r_dat   <= '0;
         r_ack   <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_next;
         r_ack   <= w_enter_ack;
         r_err   <= w_enter_ack && w_we && w_wp;
         if (r_state == IDLE && w_sel) begin
            r_cnt <= i_wait_cfg;
            r_off <= i_addr[AW-1:0];
            r_we  <= i_we;
            r_dat <= i_dat;
         end else if (r_state == WAIT && i_cs) begin
            r_cnt <= r_cnt - 1'b1;
         end
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (w_sel) w_next = (i_wait_cfg == '0) ? ACK : WAIT;
         WAIT:    if (!i_cs) w_next = IDLE;
                  else if (r_cnt == 1) w_next = ACK;
         ACK:     w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_comb begin
      w_enter_ack = (r_state != ACK) && (w_next == ACK);
      w_ram_we    = i_reset_n && w_enter_ack && w_we && !w_wp;
      w_ram_re    = i_reset_n && w_enter_ack && !w_we;
      o_busy      = (r_state != IDLE);
      o_ack       = r_ack;
      o_err       = r_err;
   end

   dcpu_ram_sp #(
      .W  (W),
      .AW (AW)
   ) u_ram (
      .i_clk     (i_clk),
      .i_reset_n (i_reset_n),
      .i_we      (w_ram_we),
      .i_re      (w_ram_re),
      .i_addr    (w_off),
      .i_wdat    (w_dat),
      .o_rdat    (o_dat)
   );

endmodule

// File: tb/tb_dcpu_mem_responder.sv
// Directed bench for dcpu_mem_responder: latency, back-to-back, write
// protect, window decode, abort and reset-in-WAIT.
module tb_dcpu_mem_responder;

   logic        i_clk = 1'b0;
   logic        i_reset_n;
   logic        i_cs;
   logic        i_we;
   logic [15:0] i_addr;
   logic [15:0] i_dat;
   logic [15:0] o_dat;
   logic        o_ack;
   logic        o_err;
   logic [3:0]  i_wait_cfg;
   logic        o_busy;

   int n_checks = 0;
   int n_fails  = 0;

   dcpu_mem_responder #(
      .W            (16),
      .AW           (10),
      .BASE         (16'h0000),
      .WP_LIMIT     (16'h0040),
      .MAXWAIT_BITS (4)
   ) dut (
      .i_clk      (i_clk),
      .i_reset_n  (i_reset_n),
      .i_cs       (i_cs),
      .i_we       (i_we),
      .i_addr     (i_addr),
      .i_dat      (i_dat),
      .o_dat      (o_dat),
      .o_ack      (o_ack),
      .o_err      (o_err),
      .i_wait_cfg (i_wait_cfg),
      .o_busy     (o_busy)
   );

   always #5 i_clk = ~i_clk;

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Issue one access and hold i_cs until ack (bounded), then release.
   task automatic do_access(input logic we, input logic [15:0] addr, input logic [15:0] dat,
                            input logic [3:0] cfg, output int lat, output logic err,
                            output logic [15:0] rd);
      i_cs = 1'b1; i_we = we; i_addr = addr; i_dat = dat; i_wait_cfg = cfg;
      lat = 0; err = 1'b0; rd = '0;
      for (int k = 1; k <= 40; k++) begin
         tick();
         if (o_ack) begin
            lat = k; err = o_err; rd = o_dat;
            break;
         end
      end
      i_cs = 1'b0;
      tick();
   endtask

   int          lat;
   int          busy_cnt;
   logic        err;
   logic [15:0] rd;
   logic [15:0] prior;

   initial begin
      i_reset_n = 1'b0; i_cs = 1'b0; i_we = 1'b0;
      i_addr = '0; i_dat = '0; i_wait_cfg = '0;
      tick(); tick();
      check("rst_ack",  o_ack,  1'b0);
      check("rst_err",  o_err,  1'b0);
      check("rst_busy", o_busy, 1'b0);
      check("rst_dat",  o_dat,  16'h0000);
      i_reset_n = 1'b1;
      tick();

      // 1: back-to-back write then read with i_cs held
      i_cs = 1'b1; i_we = 1'b1; i_addr = 16'h0100; i_dat = 16'hBEEF; i_wait_cfg = 4'd0;
      tick();
      check("t1_wr_ack", o_ack, 1'b1);
      check("t1_wr_err", o_err, 1'b0);
      i_we = 1'b0;
      tick();
      check("t1_gap_ack", o_ack, 1'b0);
      tick();
      check("t1_rd_ack", o_ack, 1'b1);
      check("t1_rd_dat", o_dat, 16'hBEEF);
      i_cs = 1'b0;
      tick();

      // 2: wait states, address change during WAIT ignored
      do_access(1'b1, 16'h0200, 16'h1234, 4'd0, lat, err, rd);
      check("t2_pre_lat", lat, 1);
      i_cs = 1'b1; i_we = 1'b0; i_addr = 16'h0200; i_wait_cfg = 4'd3;
      busy_cnt = 0; lat = 0;
      for (int k = 1; k <= 20; k++) begin
         tick();
         if (k == 1) begin
            i_addr = 16'h0100;
            i_wait_cfg = 4'd0;
         end
         if (o_busy) busy_cnt++;
         if (o_ack) begin
            lat = k;
            rd  = o_dat;
            break;
         end
      end
      check("t2_lat",  lat,      4);
      check("t2_busy", busy_cnt, 4);
      check("t2_dat",  rd,       16'h1234);
      i_cs = 1'b0;
      tick();
      check("t2_idle_busy", o_busy, 1'b0);

      // 3: write-protected region
      do_access(1'b0, 16'h0010, 16'h0000, 4'd0, lat, err, prior);
      do_access(1'b1, 16'h0010, 16'hDEAD, 4'd0, lat, err, rd);
      check("t3_lat", lat, 1);
      check("t3_err", err, 1'b1);
      check("t3_err_clear", o_err, 1'b0);
      do_access(1'b0, 16'h0010, 16'h0000, 4'd0, lat, err, rd);
      check("t3_keep", rd, prior);
      check("t3_notdead", (rd != 16'hDEAD), 1'b1);

      // 4: outside the window
      i_cs = 1'b1; i_we = 1'b0; i_addr = 16'h0800; i_wait_cfg = 4'd0;
      for (int k = 0; k < 20; k++) begin
         tick();
         check("t4_ack",  o_ack,  1'b0);
         check("t4_busy", o_busy, 1'b0);
      end
      i_cs = 1'b0;
      tick();

      // 5: abort during WAIT
      do_access(1'b1, 16'h0300, 16'h7777, 4'd0, lat, err, rd);
      i_cs = 1'b1; i_we = 1'b1; i_addr = 16'h0300; i_dat = 16'h5555; i_wait_cfg = 4'd5;
      tick(); tick();
      check("t5_busy_wait", o_busy, 1'b1);
      i_cs = 1'b0;
      tick();
      check("t5_abort_busy", o_busy, 1'b0);
      check("t5_abort_ack",  o_ack,  1'b0);
      tick(); tick();
      check("t5_noack", o_ack, 1'b0);
      do_access(1'b0, 16'h0300, 16'h0000, 4'd0, lat, err, rd);
      check("t5_old", rd, 16'h7777);

      // 6: reset during WAIT of a write
      do_access(1'b1, 16'h0304, 16'h1111, 4'd0, lat, err, rd);
      check("t6_pre_dat", o_dat, 16'h7777);
      i_cs = 1'b1; i_we = 1'b1; i_addr = 16'h0304; i_dat = 16'h2222; i_wait_cfg = 4'd4;
      tick(); tick();
      check("t6_busy_wait", o_busy, 1'b1);
      i_reset_n = 1'b0;
      tick();
      check("t6_ack",  o_ack,  1'b0);
      check("t6_busy", o_busy, 1'b0);
      check("t6_dat",  o_dat,  16'h0000);
      i_reset_n = 1'b1; i_cs = 1'b0;
      tick();
      do_access(1'b0, 16'h0304, 16'h0000, 4'd2, lat, err, rd);
      check("t6_lat", lat, 3);
      check("t6_old", rd, 16'h1111);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
